// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD write path.
//   - lcd_state_e : 3-bit FSM state codes, also shown on the debug LEDs
//   - CMD_CLEAR / CMD_HOME : commands that need the long execution wait
//   - DEF_*_CYC : default bus timing at 50 MHz, shared with the initializer
//   - is_long_cmd() : classifies a byte as a long-execution command
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_POLL  = 3'd5
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int DEF_SETUP_CYC     = 2;      // 40 ns
  localparam int DEF_EN_HIGH_CYC   = 13;     // >= 250 ns
  localparam int DEF_HOLD_CYC      = 1;
  localparam int DEF_EXEC_CYC      = 2000;   // 40 us
  localparam int DEF_LONG_EXEC_CYC = 82000;  // 1.64 ms

  // Clear (0x01) and return-home (0x02, and 0x03 since bit 0 is don't-care)
  // are the only commands with the long execution time.
  function automatic logic is_long_cmd(input logic is_data, input logic [7:0] b);
    return !is_data && ((b == CMD_CLEAR) || (b[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: down-counter used for every phase of an LCD write.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : load strobe, takes priority over counting
//   load_value  : value loaded on load (phase length - 1)
//   done        : count has reached zero (stays there until the next load)
module lcd_delay_counter #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: clocked state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: bus-timing stage for an HD44780-style LCD.
// Accepts one command/data byte per Valid/Ready handshake, then drives
// RS/Dados setup, the Enable pulse, hold and the execution wait.
//   Clock, Reset      : 50 MHz clock, asynchronous active-high reset
//   Valid, IsData     : request present; 1 = data (RS=1), 0 = command
//   Byte              : byte to write
//   Ready, Busy       : Ready high only in IDLE; Busy is its inverse
//   Enable, RS, RW    : LCD control pins (all registered)
//   Dados             : LCD data bus (registered)
//   Estado            : current FSM state code for debug LEDs
// Optional build macro LCD_BUSY_POLL_EN: adds DadosIn/DadosOE and replaces
// the fixed execution wait with busy-flag polling (timeout LONG_EXEC_CYC).
module lcd_byte_writer import lcd_pkg::*; #(
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int EN_HIGH_CYC   = DEF_EN_HIGH_CYC,
  parameter int HOLD_CYC      = DEF_HOLD_CYC,
  parameter int EXEC_CYC      = DEF_EXEC_CYC,
  parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Valid,
  input  logic       IsData,
  input  logic [7:0] Byte,
`ifdef LCD_BUSY_POLL_EN
  input  logic [7:0] DadosIn,
  output logic       DadosOE,
`endif
  output logic       Ready,
  output logic       Busy,
  output logic       Enable,
  output logic       RS,
  output logic       RW,
  output logic [7:0] Dados,
  output logic [2:0] Estado
);

  localparam int CNT_W = (LONG_EXEC_CYC > 1) ? $clog2(LONG_EXEC_CYC) : 1;

  lcd_state_e       state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_done;

`ifdef LCD_BUSY_POLL_EN
  logic             poll_pulse;   // 0 = poll setup phase, 1 = poll Enable phase
  logic [CNT_W-1:0] poll_timer;
  logic             poll_exit;

  assign poll_exit = (state == ST_POLL) &&
                     ((poll_timer == CNT_W'(LONG_EXEC_CYC - 1)) ||
                      (poll_pulse && cnt_done && !DadosIn[7]));
`else
  logic long_wait;

  assign RW = 1'b0;
`endif

  lcd_delay_counter #(.WIDTH(CNT_W)) u_delay (
    .clk        (Clock),
    .rst        (Reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .done       (cnt_done)
  );

  // Counter reload for the phase being entered; it fires on the same edge
  // as the state change so each phase lasts exactly its programmed length.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ST_IDLE: if (Valid && Ready) begin
        cnt_load  = 1'b1;
        cnt_value = CNT_W'(SETUP_CYC - 1);
      end
      ST_SETUP: if (cnt_done) begin
        cnt_load  = 1'b1;
        cnt_value = CNT_W'(EN_HIGH_CYC - 1);
      end
      ST_PULSE: if (cnt_done) begin
        cnt_load  = 1'b1;
        cnt_value = CNT_W'(HOLD_CYC - 1);
      end
      ST_HOLD: if (cnt_done) begin
        cnt_load  = 1'b1;
`ifdef LCD_BUSY_POLL_EN
        cnt_value = CNT_W'(SETUP_CYC - 1);
`else
        cnt_value = long_wait ? CNT_W'(LONG_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
`endif
      end
`ifdef LCD_BUSY_POLL_EN
      // Each poll is a read cycle: SETUP_CYC low, then EN_HIGH_CYC high.
      ST_POLL: if (cnt_done && !poll_exit) begin
        cnt_load  = 1'b1;
        cnt_value = poll_pulse ? CNT_W'(SETUP_CYC - 1) : CNT_W'(EN_HIGH_CYC - 1);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      Enable     <= 1'b0;
      RS         <= 1'b0;
      Dados      <= 8'h00;
      Ready      <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
      RW         <= 1'b0;
      DadosOE    <= 1'b1;
      poll_pulse <= 1'b0;
      poll_timer <= '0;
`else
      long_wait  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (Valid && Ready) begin
          RS        <= IsData;
          Dados     <= Byte;
`ifndef LCD_BUSY_POLL_EN
          long_wait <= is_long_cmd(IsData, Byte);
`endif
          Ready     <= 1'b0;
          state     <= ST_SETUP;
        end
        ST_SETUP: if (cnt_done) begin
          Enable <= 1'b1;
          state  <= ST_PULSE;
        end
        ST_PULSE: if (cnt_done) begin
          Enable <= 1'b0;
          state  <= ST_HOLD;
        end
        ST_HOLD: if (cnt_done) begin
`ifdef LCD_BUSY_POLL_EN
          // Switch the bus to a status read: RS=0, RW=1, release Dados.
          RS         <= 1'b0;
          RW         <= 1'b1;
          DadosOE    <= 1'b0;
          poll_pulse <= 1'b0;
          poll_timer <= '0;
          state      <= ST_POLL;
`else
          state <= ST_WAIT;
`endif
        end
`ifdef LCD_BUSY_POLL_EN
        ST_POLL: begin
          poll_timer <= poll_timer + 1'b1;
          if (poll_exit) begin
            Enable  <= 1'b0;
            RW      <= 1'b0;
            DadosOE <= 1'b1;
            Ready   <= 1'b1;
            state   <= ST_IDLE;
          end else if (cnt_done) begin
            poll_pulse <= !poll_pulse;
            Enable     <= !poll_pulse;
          end
        end
`else
        ST_WAIT: if (cnt_done) begin
          Ready <= 1'b1;
          state <= ST_IDLE;
        end
`endif
        // Unused codes (and the state absent from this build) recover to IDLE.
        default: begin
          Enable <= 1'b0;
          Ready  <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy   = !Ready;
  assign Estado = state;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb_lcd_byte_writer: directed self-checking bench for lcd_byte_writer.
// The DUT is built with a shortened execution wait (40 / 500 cycles) so the
// long-wait commands complete quickly; setup/enable/hold keep their defaults.
// Sample index j counts posedges after the accept edge (j=0 is the sample
// right after the accept), sampled on the falling edge.
module tb_lcd_byte_writer;

  localparam int T_SETUP = 2;
  localparam int T_EN    = 13;
  localparam int T_HOLD  = 1;
  localparam int T_EXEC  = 40;
  localparam int T_LONG  = 500;
  localparam int BUDGET  = 2000;

`ifdef LCD_BUSY_POLL_EN
  // Idle LCD (busy flag 0): one poll read then back to IDLE.
  localparam int EXP_SHORT    = T_SETUP + T_EN + T_HOLD + T_SETUP + T_EN;
  localparam int EXP_LONG     = EXP_SHORT;
  localparam int EXP_PULSES   = 2;
  localparam int EXP_EST_POST = 5;
`else
  localparam int EXP_SHORT    = T_SETUP + T_EN + T_HOLD + T_EXEC;   // 56
  localparam int EXP_LONG     = T_SETUP + T_EN + T_HOLD + T_LONG;   // 516
  localparam int EXP_PULSES   = 1;
  localparam int EXP_EST_POST = 4;
`endif

  logic       clk;
  logic       Reset, Valid, IsData;
  logic [7:0] Byte;
  logic       Ready, Busy, Enable, RS, RW;
  logic [7:0] Dados;
  logic [2:0] Estado;
`ifdef LCD_BUSY_POLL_EN
  logic [7:0] DadosIn;
  logic       DadosOE;
`endif

  int checks   = 0;
  int failures = 0;

  lcd_byte_writer #(
    .SETUP_CYC     (T_SETUP),
    .EN_HIGH_CYC   (T_EN),
    .HOLD_CYC      (T_HOLD),
    .EXEC_CYC      (T_EXEC),
    .LONG_EXEC_CYC (T_LONG)
  ) dut (
    .Clock   (clk),
    .Reset   (Reset),
    .Valid   (Valid),
    .IsData  (IsData),
    .Byte    (Byte),
`ifdef LCD_BUSY_POLL_EN
    .DadosIn (DadosIn),
    .DadosOE (DadosOE),
`endif
    .Ready   (Ready),
    .Busy    (Busy),
    .Enable  (Enable),
    .RS      (RS),
    .RW      (RW),
    .Dados   (Dados),
    .Estado  (Estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples every falling edge from index j0 until Ready returns or the
  // budget runs out. Reports the first Enable pulse position/width, pulse
  // count, Ready return index, Dados stability and two state snapshots.
  task automatic measure(input int j0, input logic [7:0] exp_byte, input bit scramble,
                         output int en_first, output int en_cnt, output int pulses,
                         output int ready_at, output bit dados_ok,
                         output logic [2:0] est_pulse, output logic [2:0] est_post);
    logic prev_en;
    en_first  = -1;
    en_cnt    = 0;
    pulses    = 0;
    ready_at  = -1;
    dados_ok  = 1'b1;
    est_pulse = 3'bxxx;
    est_post  = 3'bxxx;
    prev_en   = 1'b0;
    for (int j = j0; j <= BUDGET; j++) begin
      @(negedge clk);
      if (Enable && !prev_en) begin
        pulses++;
        if (en_first < 0) en_first = j;
      end
      if (Enable && pulses == 1) en_cnt++;
      prev_en = Enable;
      if (j == T_SETUP) est_pulse = Estado;
      if (j == T_SETUP + T_EN + T_HOLD) est_post = Estado;
      if (Dados !== exp_byte) dados_ok = 1'b0;
      if (Ready === 1'b1) begin
        ready_at = j;
        break;
      end
      if (scramble) Byte = Byte + 8'h13;
    end
  endtask

  // Full write: accept at the next edge, check the registered pins, then
  // follow the transaction until Ready returns. Call from a falling edge
  // with the DUT idle.
  task automatic write_and_check(input string tag, input logic is_data, input logic [7:0] b,
                                 input int exp_lat, input bit scramble);
    int en_first, en_cnt, pulses, ready_at;
    bit dados_ok;
    logic [2:0] ep, eh;
    Valid  = 1'b1;
    IsData = is_data;
    Byte   = b;
    @(negedge clk);
    check({tag, ".ready_low"}, Ready, 0);
    check({tag, ".busy_high"}, Busy, 1);
    check({tag, ".estado_setup"}, Estado, 1);
    check({tag, ".rs"}, RS, is_data);
    check({tag, ".dados"}, Dados, b);
    check({tag, ".rw"}, RW, 0);
    check({tag, ".en_setup"}, Enable, 0);
    if (!scramble) Valid = 1'b0;
    measure(1, b, scramble, en_first, en_cnt, pulses, ready_at, dados_ok, ep, eh);
    Valid = 1'b0;
    check({tag, ".en_first"}, en_first, T_SETUP);
    check({tag, ".en_width"}, en_cnt, T_EN);
    check({tag, ".pulses"}, pulses, EXP_PULSES);
    check({tag, ".latency"}, ready_at, exp_lat);
    check({tag, ".dados_stable"}, {31'd0, dados_ok}, 1);
    check({tag, ".estado_pulse"}, ep, 2);
    check({tag, ".estado_post_hold"}, eh, EXP_EST_POST);
  endtask

  typedef struct {
    logic       is_data;
    logic [7:0] b;
    int         lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int en_first, en_cnt, pulses, ready_at;
    bit dados_ok;
    logic [2:0] ep, eh;

    vecs = '{
      '{1'b1, 8'h41, EXP_SHORT},   // data 'A'
      '{1'b0, 8'h01, EXP_LONG},    // clear display
      '{1'b0, 8'h03, EXP_LONG},    // return home, bit 0 set
      '{1'b0, 8'h38, EXP_SHORT},   // function set
      '{1'b0, 8'h02, EXP_LONG},    // return home
      '{1'b0, 8'h04, EXP_SHORT},   // just above the home range
      '{1'b1, 8'h01, EXP_SHORT},   // data 0x01 is not a command
      '{1'b0, 8'h00, EXP_SHORT}    // just below the clear code
    };

    Reset  = 1'b1;
    Valid  = 1'b0;
    IsData = 1'b0;
    Byte   = 8'h00;
`ifdef LCD_BUSY_POLL_EN
    DadosIn = 8'h00;
`endif
    repeat (2) @(negedge clk);
    check("rst.ready", Ready, 1);
    check("rst.busy", Busy, 0);
    check("rst.enable", Enable, 0);
    check("rst.rs", RS, 0);
    check("rst.rw", RW, 0);
    check("rst.dados", Dados, 8'h00);
    check("rst.estado", Estado, 0);
    Reset = 1'b0;
    @(negedge clk);
    check("post_rst.ready", Ready, 1);
    check("post_rst.estado", Estado, 0);

    // Directed vector table: pulse timing and short/long wait selection.
    for (int i = 0; i < 8; i++) begin
      write_and_check($sformatf("vec%0d", i), vecs[i].is_data, vecs[i].b, vecs[i].lat, 1'b0);
      check($sformatf("vec%0d.idle_estado", i), Estado, 0);
      check($sformatf("vec%0d.dados_kept", i), Dados, vecs[i].b);
    end

    // Valid held with Byte changing while busy: only the first byte is used.
    write_and_check("hold_valid", 1'b1, 8'h55, EXP_SHORT, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_valid.no_requeue_estado", Estado, 0);
    check("hold_valid.no_requeue_dados", Dados, 8'h55);
    check("hold_valid.no_requeue_en", Enable, 0);

    // Back-to-back: second accept on the cycle Ready returns high.
    Valid  = 1'b1;
    IsData = 1'b1;
    Byte   = 8'h61;
    @(negedge clk);
    check("b2b.first_dados", Dados, 8'h61);
    measure(1, 8'h61, 1'b0, en_first, en_cnt, pulses, ready_at, dados_ok, ep, eh);
    check("b2b.first_latency", ready_at, EXP_SHORT);
    Byte = 8'h62;
    @(negedge clk);
    Valid = 1'b0;
    check("b2b.second_estado", Estado, 1);
    check("b2b.second_ready", Ready, 0);
    check("b2b.second_dados", Dados, 8'h62);
    measure(1, 8'h62, 1'b0, en_first, en_cnt, pulses, ready_at, dados_ok, ep, eh);
    check("b2b.second_en_first", en_first, T_SETUP);
    check("b2b.second_latency", ready_at, EXP_SHORT);

    // Reset in the middle of the Enable pulse drops everything at once.
    Valid  = 1'b1;
    IsData = 1'b1;
    Byte   = 8'h5A;
    @(negedge clk);
    Valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst.enable_before", Enable, 1);
    #2 Reset = 1'b1;
    #1;
    check("midrst.enable", Enable, 0);
    check("midrst.ready", Ready, 1);
    check("midrst.busy", Busy, 0);
    check("midrst.rs", RS, 0);
    check("midrst.dados", Dados, 8'h00);
    check("midrst.estado", Estado, 0);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check("midrst.ready_after", Ready, 1);
    write_and_check("after_rst", 1'b0, 8'h38, EXP_SHORT, 1'b0);

`ifdef LCD_BUSY_POLL_EN
    begin : poll_test
      int   rises, poll_ready;
      bit   rw_ok;
      logic prev_en;
      DadosIn = 8'h80;
      Valid   = 1'b1;
      IsData  = 1'b1;
      Byte    = 8'h41;
      @(negedge clk);
      Valid      = 1'b0;
      rises      = 0;
      poll_ready = -1;
      rw_ok      = 1'b1;
      prev_en    = 1'b0;
      for (int j = 1; j <= BUDGET; j++) begin
        @(negedge clk);
        if (Enable && !prev_en) begin
          rises++;
          if (rises == 5) DadosIn = 8'h00;   // 4th poll reads not-busy
        end
        prev_en = Enable;
        if (Estado == 3'd5 && (RW !== 1'b1 || DadosOE !== 1'b0)) rw_ok = 1'b0;
        if (Ready === 1'b1) begin
          poll_ready = j;
          break;
        end
      end
      check("poll.enable_rises", rises, 5);
      check("poll.rw_during", {31'd0, rw_ok}, 1);
      check("poll.latency", poll_ready, T_SETUP + T_EN + T_HOLD + 4 * (T_SETUP + T_EN));
      check("poll.rw_after", RW, 0);
      check("poll.oe_after", DadosOE, 1);
      check("poll.estado_after", Estado, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
